// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, funct3 width codes and default timeout shared by the load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] WID_B = 2'd0;
  localparam logic [1:0] WID_H = 2'd1;
  localparam logic [1:0] WID_W = 2'd2;
  localparam int unsigned LSU_TIMEOUT_DEFAULT = 256;
  // Unsupported codes (011, 110, 111) fall through to a word access.
  function automatic logic [1:0] lsu_width(input logic [2:0] f3);
    return f3 == F3_W ? WID_W :
           (f3 == F3_B || f3 == F3_BU) ? WID_B :
           (f3 == F3_H || f3 == F3_HU) ? WID_H : WID_W;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, lane-replicated store data and shifted load data for one access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [1:0] wid;
  assign wid = lsu_width(funct3_i);
  always_comb begin
    be_o    = wid == WID_W ? 4'b1111 : wid == WID_H ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off_i;
    wdata_o = wid == WID_W ? wdata_i : wid == WID_H ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
    rdata_o = rdata_i >> {off_i, 3'b000};
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bus master with timeout.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of masking the address.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  lsu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d, rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] wdata_rep, rdata_sh;
  logic [3:0]  be_q, be_d, be;
  logic        we_q, we_d, err_q, err_d, mis_q, mis_d, trap, timeout;
  logic [1:0]  wid, off;
  assign wid = lsu_width(funct3);
  assign off = wid == WID_W ? 2'b00 : wid == WID_H ? {addr[1], 1'b0} : addr[1:0];
`ifdef MISALIGN_TRAP_EN
  assign trap = (wid == WID_H && addr[0]) || (wid == WID_W && addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif
  assign timeout = cnt_q >= TIMEOUT_CYCLES - 1;
  lsu_align u_align (
    .funct3_i(funct3),
    .off_i   (off),
    .wdata_i (wdata),
    .rdata_i (mem_rdata),
    .be_o    (be),
    .wdata_o (wdata_rep),
    .rdata_o (rdata_sh)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = trap ? ST_DONE : ST_REQ;
        cnt_d   = '0;
        err_d   = 1'b0;
        mis_d   = trap;
        if (!trap) begin
          addr_d  = {addr[31:2], 2'b00};
          be_d    = be;
          wdata_d = wdata_rep;
          we_d    = req_we;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_gnt && mem_rvalid) begin
          state_d = ST_DONE;
          rdata_d = we_q ? rdata_q : rdata_sh;
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
        end else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_rvalid) begin
          state_d = ST_DONE;
          rdata_d = we_q ? rdata_q : rdata_sh;
        end else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign stall     = state_q == ST_REQ || state_q == ST_WAIT || (state_q == ST_IDLE && req_valid);
  assign done      = state_q == ST_DONE;
  assign bus_err   = done && err_q;
  assign misalign  = done && mis_q;
  assign mem_req   = state_q == ST_REQ;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses against a transaction-level model,
// on two instances (timeout 8 and the default) sharing one stimulus; sel picks the one checked.
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset, req_valid, req_we, mem_gnt, mem_rvalid;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall_w [2], done_w [2], err_w [2], mis_w [2], req_w [2], we_w [2];
  logic [31:0] rdata_w [2], maddr_w [2], mwdata_w [2];
  logic [3:0]  be_w [2];
  int          sel, n_pass, n_tot;
  bit          chk_en;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_we, e_stall, e_done, e_err, e_mis, e_req;
  int          done_k, n_done, n_req, n_hs;
  logic        err_seen, mis_seen, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    load_store_unit #(.TIMEOUT_CYCLES(g == 0 ? 8 : 256)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall_w[g]), .rdata(rdata_w[g]), .done(done_w[g]),
      .bus_err(err_w[g]), .misalign(mis_w[g]), .mem_req(req_w[g]), .mem_we(we_w[g]),
      .mem_addr(maddr_w[g]), .mem_be(be_w[g]), .mem_wdata(mwdata_w[g]), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );
  end

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    else n_pass++;
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) if (chk_en) begin
    chkb("stall", stall_w[sel], e_stall);
    chkb("done", done_w[sel], e_done);
    chkb("bus_err", err_w[sel], e_err);
    chkb("misalign", mis_w[sel], e_mis);
    chkb("mem_req", req_w[sel], e_req);
    chkb("mem_we", we_w[sel], m_we);
    chkw("mem_addr", maddr_w[sel], m_addr);
    chkw("mem_be", 32'(be_w[sel]), 32'(m_be));
    chkw("mem_wdata", mwdata_w[sel], m_wdata);
    chkw("rdata", rdata_w[sel], m_rdata);
  end

  task automatic set_idle_exp();
    e_stall = 0; e_done = 0; e_err = 0; e_mis = 0; e_req = 0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(posedge clk); #1;
    reset = 1; req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    @(posedge clk); #1;
    m_rdata = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_we = 0;
    set_idle_exp();
    chk_en = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      req_valid = 0; req_we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      mem_gnt = 0; mem_rvalid = $urandom_range(0, 3) == 0; mem_rdata = $urandom;
      set_idle_exp();
      #1;
    end
  endtask

  // Model: an access is a timeline of cycles k=0 (request seen in IDLE), bus cycles
  // k=1..e+1 counted from the first mem_req cycle, then one done cycle.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int gd, input int rd, input logic [31:0] rword);
    int t, sz, off, e, glast, len, lim;
    bit trap, ok, granted;
    logic [31:0] wrep, rexp;
    logic [3:0] be;
    t = sel == 0 ? 8 : 256;
    sz = 1 << (f3[1:0] == 2'b11 ? 2 : int'(f3[1:0]));
    trap = TRAP && (int'(a[1:0]) % sz != 0);
    off = int'(a[1:0]) - int'(a[1:0]) % sz;
    be = 4'(((1 << sz) - 1) << off);
    for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % sz) +: 8];
    rexp = rword >> (8 * off);
    granted = gd <= t - 1;
    if (!granted) begin ok = 0; e = t - 1; glast = e; end
    else if (rd == 0) begin ok = 1; e = gd; glast = gd; end
    else begin
      lim = gd + 1 > t - 1 ? gd + 1 : t - 1;
      ok = gd + rd <= lim;
      e = ok ? gd + rd : lim;
      glast = gd;
    end
    len = trap ? 2 : e + 3;
    done_k = -1; n_done = 0; n_req = 0; n_hs = 0; err_seen = 0; mis_seen = 0;
    cap_addr = 0; cap_be = 0; cap_wdata = 0; cap_we = 0;
    for (int k = 0; k < len; k++) begin
      int i;
      @(posedge clk); #1;
      i = k - 1;
      req_valid = 1; req_we = we; funct3 = f3; addr = a; wdata = wd;
      mem_gnt = !trap && granted && i == gd;
      mem_rvalid = !trap && ok && i == gd + rd;
      mem_rdata = mem_rvalid ? rword : $urandom;
      if (k == 1 && !trap) begin m_addr = {a[31:2], 2'b00}; m_be = be; m_wdata = wrep; m_we = we; end
      if (k == len - 1 && !trap && ok && !we) m_rdata = rexp;
      e_stall = k < len - 1;
      e_done = k == len - 1;
      e_err = e_done && !trap && !ok;
      e_mis = e_done && trap;
      e_req = !trap && k >= 1 && i <= glast;
      #1;
      if (done_w[sel]) begin n_done++; done_k = k; err_seen = err_w[sel]; mis_seen = mis_w[sel]; end
      if (req_w[sel]) begin
        if (n_req == 0) begin cap_addr = maddr_w[sel]; cap_be = be_w[sel]; cap_wdata = mwdata_w[sel]; cap_we = we_w[sel]; end
        n_req++;
        if (mem_gnt) n_hs++;
      end
    end
  endtask

  task automatic random_accesses(input int cnt);
    for (int j = 0; j < cnt; j++) begin
      run_access(1'($urandom), 3'($urandom), $urandom, $urandom,
                 sel == 0 ? $urandom_range(0, 9) : $urandom_range(0, 6), $urandom_range(0, 6), $urandom);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_tot = 0; chk_en = 0; sel = 1; reset = 1;
    req_valid = 0; req_we = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    set_idle_exp();
    do_reset();
    chkw("reset_rdata", rdata_w[sel], 32'h0);
    chkw("reset_mem_addr", maddr_w[sel], 32'h0);
    idle(2);
    run_access(1'b0, F3_W, 32'h100, $urandom, 0, 0, 32'hDEADBEEF);
    chkw("lw_done_cycle", 32'(done_k), 32'd2);
    chkw("lw_mem_addr", cap_addr, 32'h100);
    chkw("lw_be", 32'(cap_be), 32'hF);
    chkw("lw_rdata", rdata_w[sel], 32'hDEADBEEF);
    idle(1);
    run_access(1'b1, F3_B, 32'h203, 32'h000000A5, 0, 0, $urandom);
    chkw("sb_mem_addr", cap_addr, 32'h200);
    chkw("sb_be", 32'(cap_be), 32'h8);
    chkw("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    chkb("sb_we", cap_we, 1'b1);
    run_access(1'b0, F3_HU, 32'h402, $urandom, 0, 0, 32'h1234ABCD);
    chkw("lhu_be", 32'(cap_be), 32'hC);
    chkw("lhu_rdata", rdata_w[sel], 32'h00001234);
    idle(1);
    run_access(1'b0, F3_W, 32'h500, $urandom, 5, 3, 32'h0BADF00D);
    chkw("delay_done_count", 32'(n_done), 32'd1);
    chkw("delay_handshakes", 32'(n_hs), 32'd1);
    chkw("delay_done_cycle", 32'(done_k), 32'd10);
    idle(1);
    run_access(1'b0, F3_W, 32'h101, $urandom, 0, 0, 32'h11223344);
`ifdef MISALIGN_TRAP_EN
    chkw("mis_req_cycles", 32'(n_req), 32'd0);
    chkb("mis_flag", mis_seen, 1'b1);
`else
    chkw("mis_masked_addr", cap_addr, 32'h100);
    chkw("mis_issued", 32'(n_req), 32'd1);
`endif
    idle(1);
    random_accesses(40);
    chk_en = 0;
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; funct3 = F3_W; addr = 32'h300; mem_gnt = 0; mem_rvalid = 0;
    @(posedge clk); #1;
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    do_reset();
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_rvalid = 0;
    #1;
    chkw("rst_late_rvalid_rdata", rdata_w[sel], 32'h0);
    chkb("rst_late_rvalid_stall", stall_w[sel], 1'b0);
    chk_en = 0;
    sel = 0;
    do_reset();
    idle(1);
    run_access(1'b0, F3_W, 32'h600, $urandom, 1000, 0, $urandom);
    chkw("to_done_count", 32'(n_done), 32'd1);
    chkb("to_bus_err", err_seen, 1'b1);
    chkw("to_done_cycle", 32'(done_k), 32'd9);
    chkw("to_handshakes", 32'(n_hs), 32'd0);
    idle(1);
    chkb("to_then_idle", stall_w[sel], 1'b0);
    random_accesses(40);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 256: the maximum number of cycles spent waiting in REQ or WAIT before an access is aborted.
REQ-002 The module SHALL have ports, in order:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline requests a load or store this cycle.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  byte address (the ALU result).
- wdata  in  32  store data (the rs2 value).
- stall  out  1  holds the pipeline; request inputs are stable while it is high.
- rdata  out  32  load data, with the addressed byte shifted to bits [7:0].
- done  out  1  one-cycle pulse: access complete.
- bus_err  out  1  one-cycle pulse with done: access timed out.
- misalign  out  1  one-cycle pulse with done: misaligned access.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word-aligned bus address; bits [1:0] are 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  bus accepted the request.
- mem_rvalid  in  1  bus response; returned for both loads and stores.
- mem_rdata  in  32  bus read word.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-004 In IDLE, req_valid=1 SHALL transition the FSM to REQ, and stall SHALL be asserted combinationally in that same cycle.
REQ-005 In REQ, the module SHALL drive mem_req=1 with the address, enables and data registered at request capture, and SHALL transition to WAIT on mem_gnt=1.
REQ-006 In WAIT, mem_rvalid=1 SHALL transition the FSM to DONE and SHALL register rdata (for loads only).
REQ-007 mem_gnt and mem_rvalid high in the same REQ cycle SHALL transition the FSM directly to DONE.
REQ-008 In DONE, the module SHALL drive stall=0 and done=1 and SHALL ignore req_valid; the next state SHALL be IDLE, so each request is issued exactly once.
REQ-009 stall SHALL be 1 in REQ and WAIT, and also in IDLE when req_valid=1.
REQ-010 Every access SHALL occupy at least 3 cycles, with the done pulse in the third cycle when the bus grants and responds with zero wait.
REQ-011 Byte enables SHALL be:
- b/bu: 1<<addr[1:0].
- h/hu: addr[1] ? 1100 : 0011.
- w: 1111.
REQ-012 Store data SHALL be replicated across lanes: wdata[7:0] ×4 for b, wdata[15:0] ×2 for h, and wdata unchanged for w.
REQ-013 Load data SHALL be rdata = mem_rdata >> (8*addr[1:0]), zero-filled; sign or zero extension is done downstream.
REQ-014 A 32-bit wait counter SHALL clear on entry to REQ and count each cycle in REQ or WAIT.
REQ-015 When the wait counter reaches TIMEOUT_CYCLES-1 without the awaited handshake, the FSM SHALL go to DONE with bus_err=1 and rdata unchanged.
REQ-016 An unsupported funct3 (011, 110, 111) SHALL be treated as w.
REQ-017 Outside REQ, mem_req SHALL be 0 and mem_we, mem_addr, mem_be and mem_wdata SHALL hold their last values.

Reset
REQ-018 reset SHALL return the FSM to IDLE and clear the wait counter, mem_req, done, bus_err and misalign.
REQ-019 reset SHALL set rdata, mem_addr, mem_wdata, mem_be and mem_we to 0.
REQ-020 A reset asserted in REQ or WAIT SHALL abandon the access, and a late mem_rvalid arriving in IDLE SHALL be ignored.

Configuration
REQ-021 With MISALIGN_TRAP_EN defined, a misaligned access (h with addr[0]=1, or w with addr[1:0]≠00) SHALL go IDLE→DONE with misalign=1, no bus transaction, and rdata unchanged.
REQ-022 Without MISALIGN_TRAP_EN, misalign SHALL be tied to 0, and the access SHALL be issued with addr bits masked to natural alignment (h: addr[0]=0; w: addr[1:0]=00).

Structure
REQ-023 The lsu_pkg package SHALL hold the FSM state enum, the funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the default value of TIMEOUT_CYCLES.
REQ-024 A combinational sub-module lsu_align SHALL compute mem_be, replicated store data and shifted load data from funct3, addr[1:0], wdata and mem_rdata.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Zero-wait lw at addr 0x100 with mem_rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, done in cycle 3, rdata=0xDEADBEEF.
- sb at addr 0x203 with wdata=0x000000A5 -> mem_addr=0x200, be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
- lhu at addr 0x402 with mem_rdata=0x1234ABCD -> be=1100, rdata=0x00001234.
- gnt delayed 5 cycles and rvalid delayed 3 cycles -> stall high throughout, single mem_req handshake, exactly one done pulse.
- mem_gnt never asserted with TIMEOUT_CYCLES=8 -> done and bus_err pulse together, then IDLE.
- lw at addr 0x101 with MISALIGN_TRAP_EN -> misalign=1, mem_req never asserted; without the macro -> mem_addr=0x100 and the access issued.
